reg_file_param: RTL and testbench

- Parametrised successor to the MIPS integer register file.
- Two asynchronous read ports and one synchronous write port.
- Byte, half-word and word access sizes on the write port and on read port 2; sign or zero extension on read port 2.
- Optional hardwired-zero entry 0.
- After reset, a hardware clear sequencer sweeps the array to zero, so storage needs no reset fan-out and can map to distributed RAM.

---
 rtl/reg_file_param.sv | 134 +++++++++++++
 tb/tb_reg_file_param.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parametrised register file: two async read ports, one sync write port, sub-word access.
// Define REGFILE_BYPASS_EN to enable write-through bypass from the write port to both read ports.
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic [1:0]        rd_size2,
    input  logic              rd_signed2,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        wr_size
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              clr_we;
    logic              wr_ok;
    logic [DATA_W-1:0] word1, word2;
    logic [DATA_W-1:0] mem [DEPTH];

    // Entry 0 under ZERO_REG and anything past DEPTH behave as non-existent storage.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        addr_ok = ({1'b0, a} < (ADDR_W+1)'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [DATA_W-1:0] lane_mask(input logic [1:0] size);
        logic [DATA_W-1:0] m;
        m = '0;
        case (size)
            2'b01:   m[15:0] = '1;
            2'b10:   m[7:0]  = '1;
            default: m       = '1;
        endcase
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [1:0]        size);
        logic [DATA_W-1:0] m;
        m = lane_mask(size);
        return (old_w & ~m) | (new_w & m);
    endfunction

    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] w,
                                                 input logic [1:0]        size,
                                                 input logic              sgn);
        logic [DATA_W-1:0] r;
        case (size)
            2'b01: begin
                r       = {DATA_W{sgn & w[15]}};
                r[15:0] = w[15:0];
            end
            2'b10: begin
                r      = {DATA_W{sgn & w[7]}};
                r[7:0] = w[7:0];
            end
            default: r = w;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Clear sweep: one entry per edge, then hand the file over to the datapath.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_we      = 1'b0;
        ready       = 1'b0;
        case (state)
            CLEAR: begin
                clr_we      = rst_n;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                    state_nxt   = RUN;
                    clr_cnt_nxt = '0;
                end
            end
            RUN: ready = 1'b1;
            default: state_nxt = CLEAR;
        endcase
    end

    assign wr_ok = (state == RUN) && wr_en && addr_ok(wr_addr);

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_cnt[IDX_W-1:0]] <= '0;
        else if (wr_ok)
            mem[wr_addr[IDX_W-1:0]] <= merge(mem[wr_addr[IDX_W-1:0]], wr_data, wr_size);
    end

    always_comb begin
        word1 = '0;
        word2 = '0;
        if (addr_ok(rd_addr1))
            word1 = mem[rd_addr1[IDX_W-1:0]];
        if (addr_ok(rd_addr2))
            word2 = mem[rd_addr2[IDX_W-1:0]];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (wr_addr == rd_addr1))
            word1 = merge(word1, wr_data, wr_size);
        if (wr_ok && (wr_addr == rd_addr2))
            word2 = merge(word2, wr_data, wr_size);
`endif
        rd_data1 = ready ? word1 : '0;
        rd_data2 = ready ? extend(word2, rd_size2, rd_signed2) : '0;
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: a default instance plus a DEPTH=24 instance sharing all inputs.
module tb_reg_file_param;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready, ready_b;
    logic [4:0]  rd_addr1 = '0, rd_addr2 = '0, wr_addr = '0;
    logic [1:0]  rd_size2 = '0, wr_size = '0;
    logic        rd_signed2 = 1'b0, wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data1, rd_data2, rd_data1_b, rd_data2_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_file_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .ready(ready),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1),
        .rd_addr2(rd_addr2), .rd_size2(rd_size2), .rd_signed2(rd_signed2), .rd_data2(rd_data2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_size(wr_size)
    );

    reg_file_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(24), .ZERO_REG(1)) dut24 (
        .clk(clk), .rst_n(rst_n), .ready(ready_b),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1_b),
        .rd_addr2(rd_addr2), .rd_size2(rd_size2), .rd_signed2(rd_signed2), .rd_data2(rd_data2_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_size(wr_size)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [1:0] s);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_size = s;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        logic exp;
        rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %0b want 0", ready); end
        n_cmp++;
        if (ready_b !== 1'b0) begin n_fail++; $display("FAIL reset_ready24 got %0b want 0", ready_b); end
        rst_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            exp = (i >= 32);
            n_cmp++;
            if (ready !== exp) begin n_fail++; $display("FAIL sweep_ready cycle %0d got %0b want %0b", i, ready, exp); end
            if (i == 23 || i == 24) begin
                exp = (i >= 24);
                n_cmp++;
                if (ready_b !== exp) begin n_fail++; $display("FAIL sweep_ready24 cycle %0d got %0b want %0b", i, ready_b, exp); end
            end
        end
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a);
            rd_addr2 = 5'(a);
            rd_size2 = 2'b00;
            #1;
            n_cmp++;
            if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
                n_fail++;
                $display("FAIL sweep_zero addr %0d got %h/%h want 00000000", a, rd_data1, rd_data2);
            end
        end
    endtask

    task automatic test_subword();
        rd_addr1 = 5'd7;
        do_write(5'd7, 32'h1122_3344, 2'b00);
        #1;
        n_cmp++;
        if (rd_data1 !== 32'h1122_3344) begin n_fail++; $display("FAIL word_write got %h want 11223344", rd_data1); end
        do_write(5'd7, 32'hAAAA_BEEF, 2'b01);
        #1;
        n_cmp++;
        if (rd_data1 !== 32'h1122_BEEF) begin n_fail++; $display("FAIL half_write got %h want 1122beef", rd_data1); end
        do_write(5'd7, 32'h0000_0080, 2'b10);
        #1;
        n_cmp++;
        if (rd_data1 !== 32'h1122_BE80) begin n_fail++; $display("FAIL byte_write got %h want 1122be80", rd_data1); end
    endtask

    task automatic test_extend();
        logic [1:0]  sz [6] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b11};
        logic        sg [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] ex [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_BE80,
                                32'h0000_BE80, 32'h1122_BE80, 32'h1122_BE80};
        rd_addr2 = 5'd7;
        for (int k = 0; k < 6; k++) begin
            rd_size2   = sz[k];
            rd_signed2 = sg[k];
            #1;
            n_cmp++;
            if (rd_data2 !== ex[k]) begin
                n_fail++;
                $display("FAIL extend size %b signed %b got %h want %h", sz[k], sg[k], rd_data2, ex[k]);
            end
        end
    endtask

    task automatic test_zero_range();
        do_write(5'd0, 32'h0000_0005, 2'b00);
        rd_addr1   = 5'd0;
        rd_addr2   = 5'd0;
        rd_size2   = 2'b10;
        rd_signed2 = 1'b1;
        #1;
        n_cmp++;
        if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
            n_fail++; $display("FAIL zero_reg got %h/%h want 00000000", rd_data1, rd_data2);
        end
        n_cmp++;
        if (rd_data1_b !== 32'h0 || rd_data2_b !== 32'h0) begin
            n_fail++; $display("FAIL zero_reg24 got %h/%h want 00000000", rd_data1_b, rd_data2_b);
        end
        do_write(5'd30, 32'hA5A5_A5A5, 2'b00);
        rd_addr1 = 5'd30;
        rd_addr2 = 5'd30;
        rd_size2 = 2'b00;
        #1;
        n_cmp++;
        if (rd_data1_b !== 32'h0 || rd_data2_b !== 32'h0) begin
            n_fail++; $display("FAIL out_of_range24 got %h/%h want 00000000", rd_data1_b, rd_data2_b);
        end
        n_cmp++;
        if (rd_data1 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL in_range32 got %h want a5a5a5a5", rd_data1); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp;
        rd_addr1   = 5'd3;
        rd_addr2   = 5'd3;
        rd_size2   = 2'b10;
        rd_signed2 = 1'b0;
        #1;
        n_cmp++;
        if (rd_data1 !== 32'h0) begin n_fail++; $display("FAIL r3_initial got %h want 00000000", rd_data1); end
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'hCAFE_F00D;
        wr_size = 2'b00;
        #1;
        exp = BYP ? 32'hCAFE_F00D : 32'h0;
        n_cmp++;
        if (rd_data1 !== exp) begin n_fail++; $display("FAIL same_cycle_p1 got %h want %h", rd_data1, exp); end
        exp = BYP ? 32'h0000_000D : 32'h0;
        n_cmp++;
        if (rd_data2 !== exp) begin n_fail++; $display("FAIL same_cycle_p2 got %h want %h", rd_data2, exp); end
        tick();
        wr_en = 1'b0;
        #1;
        n_cmp++;
        if (rd_data1 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL next_cycle got %h want cafef00d", rd_data1); end
        wr_en   = 1'b1;
        wr_data = 32'h0000_0077;
        wr_size = 2'b10;
        #1;
        exp = BYP ? 32'hCAFE_F077 : 32'hCAFE_F00D;
        n_cmp++;
        if (rd_data1 !== exp) begin n_fail++; $display("FAIL same_cycle_byte got %h want %h", rd_data1, exp); end
        tick();
        wr_en = 1'b0;
        #1;
        n_cmp++;
        if (rd_data1 !== 32'hCAFE_F077) begin n_fail++; $display("FAIL byte_after got %h want cafef077", rd_data1); end
        rd_addr1 = 5'd0;
        wr_en    = 1'b1;
        wr_addr  = 5'd0;
        wr_data  = 32'hFFFF_FFFF;
        wr_size  = 2'b00;
        #1;
        n_cmp++;
        if (rd_data1 !== 32'h0) begin n_fail++; $display("FAIL same_cycle_r0 got %h want 00000000", rd_data1); end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic exp;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        rst_n    = 1'b0;
        wr_en    = 1'b1;
        wr_addr  = 5'd5;
        wr_data  = 32'hDEAD_BEEF;
        wr_size  = 2'b00;
        rd_addr1 = 5'd7;
        #1;
        n_cmp++;
        if (ready !== 1'b0 || rd_data1 !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset got ready %0b data %h want 0/00000000", ready, rd_data1);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            exp = (i >= 32);
            n_cmp++;
            if (ready !== exp) begin n_fail++; $display("FAIL resweep_ready cycle %0d got %0b want %0b", i, ready, exp); end
            if (i == 3) begin
                n_cmp++;
                if (rd_data1 !== 32'h0) begin n_fail++; $display("FAIL clear_forced_read got %h want 00000000", rd_data1); end
            end
        end
        wr_en      = 1'b0;
        rd_addr1   = 5'd5;
        rd_addr2   = 5'd7;
        rd_size2   = 2'b00;
        #1;
        n_cmp++;
        if (rd_data1 !== 32'h0) begin n_fail++; $display("FAIL r5_after_clear got %h want 00000000", rd_data1); end
        n_cmp++;
        if (rd_data2 !== 32'h0) begin n_fail++; $display("FAIL r7_after_clear got %h want 00000000", rd_data2); end
    endtask

    initial begin
        test_reset();
        test_subword();
        test_extend();
        test_zero_range();
        test_same_cycle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
